// File: rtl/stream_probe_pkg.sv
// Shared types and helpers for the stream probe recorder: the captured record
// layout and the saturating increment used by the statistics counters.
package stream_probe_pkg;

    localparam int REC_DATA_W = 64;
    localparam int REC_TS_W   = 32;
    localparam int SAT_MAX_W  = 64;

    typedef struct packed {
        logic [REC_DATA_W-1:0] data;
        logic [REC_TS_W-1:0]   ts;
    } probe_rec_t;

    // Increments value, holding at the all-ones pattern of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                      input int width);
        logic [SAT_MAX_W-1:0] max_val;
        if (width >= SAT_MAX_W)
            max_val = '1;
        else
            max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/probe_rec_fifo.sv
// Single-clock record FIFO with a registered head word. The head register is
// part of the occupancy, so the backing memory holds at most DEPTH-1 entries.
module probe_rec_fifo
    import stream_probe_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_p1;
    logic [WIDTH-1:0] head_p1;
    logic             pop;
    logic             push;
    logic             mem_has_data;
    logic             load_head;
    logic             mem_wr;

    assign rd_vld       = (level_p1 != '0);
    assign full         = (level_p1 == LVL_W'(DEPTH));
    assign pop          = rd_en & rd_vld;
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign push         = wr_en & (!full | pop);
    assign mem_has_data = (level_p1 > LVL_W'(1));
    assign load_head    = pop | !rd_vld;
    assign mem_wr       = push & !(load_head & !mem_has_data);

    assign rd_data = head_p1;
    assign level   = level_p1;

    // Stage p1: occupancy, pointers and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            level_p1 <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_p1  <= '0;
        end else begin
            level_p1 <= level_p1 + LVL_W'(push) - LVL_W'(pop);
            if (mem_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_head) begin
                if (mem_has_data) begin
                    head_p1 <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end else if (push) begin
                    head_p1 <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/stream_probe_recorder.sv
// Passive valid/ready probe: timestamps completed transfers into a record FIFO
// and keeps saturating transfer, stall and drop statistics.
module stream_probe_recorder
    import stream_probe_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    input  logic                        CLEAR,
    input  logic [DATA_WIDTH-1:0]       PROBE_DATA,
    input  logic                        PROBE_VLD,
    input  logic                        PROBE_RDY,
    output logic [DATA_WIDTH-1:0]       REC_DATA,
    output logic [TS_WIDTH-1:0]         REC_TS,
    output logic                        REC_VLD,
    input  logic                        REC_RDY,
    output logic [CNT_WIDTH-1:0]        CNT_XFER,
    output logic [CNT_WIDTH-1:0]        CNT_STALL,
    output logic [CNT_WIDTH-1:0]        CNT_DROP,
    output logic                        OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

    localparam int REC_W = DATA_WIDTH + TS_WIDTH;

    logic [TS_WIDTH-1:0] ts_p0;
    logic                ev_capture;
    logic                ev_stall;
    logic                ev_drop;
    logic                rec_pop;
    logic                fifo_full;
    logic [REC_W-1:0]    rec_head;

    // CLEAR wins over the stored count, but an event in the same cycle still lands.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic ev,
                                                      input logic clr);
        if (clr)
            return CNT_WIDTH'(ev);
        if (ev)
            return CNT_WIDTH'(sat_inc(SAT_MAX_W'(cur), CNT_WIDTH));
        return cur;
    endfunction

    // Stage p0: event decode on the probed bus
    assign ev_capture = ENABLE & PROBE_VLD & PROBE_RDY;
    assign ev_stall   = ENABLE & PROBE_VLD & !PROBE_RDY;
    assign rec_pop    = REC_VLD & REC_RDY;
    assign ev_drop    = ev_capture & fifo_full & !rec_pop;

    always_ff @(posedge CLK) begin
        if (RESET)
            ts_p0 <= '0;
        else
            ts_p0 <= ts_p0 + TS_WIDTH'(1);
    end

    // Stage p1: statistics registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CNT_XFER  <= '0;
            CNT_STALL <= '0;
            CNT_DROP  <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            CNT_XFER  <= cnt_next(CNT_XFER, ev_capture, CLEAR);
            CNT_STALL <= cnt_next(CNT_STALL, ev_stall, CLEAR);
            CNT_DROP  <= cnt_next(CNT_DROP, ev_drop, CLEAR);
            if (CLEAR)
                OVERFLOW <= ev_drop;
            else if (ev_drop)
                OVERFLOW <= 1'b1;
        end
    end

    probe_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (ev_capture),
        .wr_data ({PROBE_DATA, ts_p0}),
        .rd_en   (REC_RDY),
        .rd_data (rec_head),
        .rd_vld  (REC_VLD),
        .full    (fifo_full),
        .level   (FIFO_LEVEL)
    );

    assign {REC_DATA, REC_TS} = rec_head;

endmodule
